// File: rtl/segment_step_pkg.sv
// -----------------------------------------------------------------------------
// segment_step_pkg
// Shared definitions for the segment step generator:
//   - state_t  : 2-bit FSM encoding (IDLE=0, PRESS_WAIT=1, PRESSED=2,
//                RELEASE_WAIT=3)
//   - DEFAULT_*: default timing constants, in clk cycles
//   - is_held(): true for the states in which the button counts as pressed
// -----------------------------------------------------------------------------
package segment_step_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

    // The button is still logically held while a release is being debounced.
    function automatic logic is_held(input state_t s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

endpackage : segment_step_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk          : destination clock
//   async_nreset : asynchronous active-low reset, clears both flops to 0
//   d            : asynchronous input level
//   q            : synchronized level (second flop output)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic async_nreset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops use non-blocking assignments so both stages sample their
    // inputs on the same edge; a blocking assignment would collapse the
    // chain into a single flop.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/segment_step_gen.sv
// -----------------------------------------------------------------------------
// segment_step_gen
// Debounces a raw push-button and emits a one-cycle step pulse per accepted
// press for the segment rotator. Optional auto-repeat while the button is
// held, enabled by defining SEGMENT_STEP_AUTOREPEAT_EN.
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a press or a release
//   REPEAT_DELAY    : cycles from the first pulse to the first repeat pulse
//   REPEAT_PERIOD   : cycles between subsequent repeat pulses
// Ports:
//   clk             : clock, all state updates on the rising edge
//   async_nreset    : asynchronous active-low reset
//   btn_raw         : raw bouncing button level, active-high, asynchronous
//   next_segment_re : registered one-cycle step pulse
//   btn_level       : registered debounced button level
// -----------------------------------------------------------------------------
module segment_step_gen
    import segment_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic btn_raw,
    output logic next_segment_re,
    output logic btn_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("segment_step_gen: timing parameters must all be >= 1");
    end

    logic             btn_sync;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             press_accept;
    logic             first_pressed;
    logic             rpt_hit;
    logic             pulse_req;

    sync_2ff u_sync (
        .clk          (clk),
        .async_nreset (async_nreset),
        .d            (btn_raw),
        .q            (btn_sync)
    );

    // The debounce counter is shared: it times the press in PRESS_WAIT and
    // the release in RELEASE_WAIT, and is restarted on entry to either.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync)              state_next = IDLE;
                else if (cnt == CNT_LAST)   state_next = PRESSED;
                else                        cnt_next   = cnt + CNT_W'(1);
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync)               state_next = PRESSED;
                else if (cnt == CNT_LAST)   state_next = IDLE;
                else                        cnt_next   = cnt + CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Only a fresh press pulses; a bounce back from RELEASE_WAIT does not.
    assign press_accept = (state == PRESS_WAIT) && (state_next == PRESSED);

`ifdef SEGMENT_STEP_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_limit;
    logic             rpt_armed;

    // rpt_cnt holds the number of PRESSED cycles since the last pulse, so a
    // hit lines up with the registered first pulse exactly REPEAT_DELAY (then
    // REPEAT_PERIOD) cycles later.
    always_comb begin
        rpt_limit = rpt_armed ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
        rpt_hit   = (state == PRESSED) && (rpt_cnt == rpt_limit);
    end

    // Frozen while a release is being debounced so a short bounce does not
    // restart the repeat cadence; cleared once the press is over.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else begin
            case (state)
                PRESSED: begin
                    if (rpt_hit) begin
                        rpt_cnt   <= RPT_W'(1);
                        rpt_armed <= 1'b1;
                    end else begin
                        rpt_cnt   <= rpt_cnt + RPT_W'(1);
                    end
                end
                RELEASE_WAIT: ;
                default: begin
                    rpt_cnt   <= '0;
                    rpt_armed <= 1'b0;
                end
            endcase
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    assign pulse_req = first_pressed || rpt_hit;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state           <= IDLE;
            cnt             <= '0;
            first_pressed   <= 1'b0;
            btn_level       <= 1'b0;
            next_segment_re <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            first_pressed   <= press_accept;
            btn_level       <= is_held(state);
            // Guarantees the pulse is never high on two consecutive cycles,
            // even with REPEAT_PERIOD or REPEAT_DELAY of 1.
            next_segment_re <= pulse_req && !next_segment_re;
        end
    end

endmodule : segment_step_gen

// File: tb/tb_segment_step_gen.sv
// -----------------------------------------------------------------------------
// tb_segment_step_gen
// Self-checking bench for segment_step_gen with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expectations follow the build's
// SEGMENT_STEP_AUTOREPEAT_EN setting.
// -----------------------------------------------------------------------------
module tb_segment_step_gen;

    localparam int DEB    = 4;
    localparam int RDELAY = 10;
    localparam int RPER   = 3;

    logic clk = 1'b0;
    logic async_nreset;
    logic btn_raw;
    logic next_segment_re;
    logic btn_level;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic raw;
        logic pulse;
        logic level;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    segment_step_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDELAY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clk             (clk),
        .async_nreset    (async_nreset),
        .btn_raw         (btn_raw),
        .next_segment_re (next_segment_re),
        .btn_level       (btn_level)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Append n identical per-cycle records.
    task automatic push(input int n, input logic r, input logic p, input logic l);
        vec_t v;
        v.raw = r; v.pulse = p; v.level = l;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // The step pulse must never be high two cycles in a row.
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (async_nreset === 1'b1 && next_segment_re === 1'b1)
            check("no_back_to_back", prev_pulse, 1'b0);
        prev_pulse = next_segment_re;
    end

    function automatic logic exp_repeat(input int k);
`ifdef SEGMENT_STEP_AUTOREPEAT_EN
        return (k >= RDELAY) && (((k - RDELAY) % RPER) == 0);
`else
        return (k == -1);
`endif
    endfunction

    initial begin
        // --- Sequence A: clean press held 20 cycles, then release ----------
        // Step k = output after the k-th edge that samples the new btn_raw.
        push(7, 1, 0, 0);
        push(1, 1, 1, 1);                 // pulse 7 edges after first sample
`ifdef SEGMENT_STEP_AUTOREPEAT_EN
        push(9, 1, 0, 1);
        push(1, 1, 1, 1);                 // repeat at +10
        push(2, 1, 0, 1);
        push(1, 0, 1, 1);                 // repeat at +13 (release still in sync)
        push(6, 0, 0, 1);
`else
        push(12, 1, 0, 1);
        push(7, 0, 0, 1);                 // release being debounced
`endif
        push(3, 0, 0, 0);
        // --- Sequence B: 3-cycle glitch, rejected -------------------------
        push(3, 1, 0, 0);
        push(5, 0, 0, 0);
        // --- Sequence C: press, 2-cycle drop, re-press, then release ------
        push(7, 1, 0, 0);
        push(1, 1, 1, 1);
        push(1, 1, 0, 1);
        push(2, 0, 0, 1);                 // bounce low: no new pulse, level held
        push(3, 1, 0, 1);
        push(7, 0, 0, 1);
        push(3, 0, 0, 0);

        // --- Reset state ---------------------------------------------------
        async_nreset = 1'b0;
        btn_raw      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulse", next_segment_re, 1'b0);
        check("reset_level", btn_level, 1'b0);
        @(negedge clk);
        async_nreset = 1'b1;
        repeat (3) @(negedge clk);

        // --- Table-driven vectors -------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            btn_raw = vecs[i].raw;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulse", i), next_segment_re, vecs[i].pulse);
            check($sformatf("vec%0d_level", i), btn_level, vecs[i].level);
        end

        // --- Reset mid-hold aborts the press, one new pulse follows ---------
        @(negedge clk);
        btn_raw = 1'b1;
        repeat (12) @(negedge clk);
        check("hold_level_before_reset", btn_level, 1'b1);
        #2;
        async_nreset = 1'b0;
        #1;
        check("async_reset_level", btn_level, 1'b0);
        check("async_reset_pulse", next_segment_re, 1'b0);
        @(negedge clk);
        async_nreset = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset%0d_pulse", k), next_segment_re, logic'(k == 7));
            check($sformatf("post_reset%0d_level", k), btn_level, logic'(k >= 7));
        end
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_release_level", btn_level, 1'b0);

        // --- Long hold: auto-repeat cadence or a single pulse ----------------
        begin
            int npulse = 0;
            @(negedge clk);
            btn_raw = 1'b1;
            for (int k = 0; k < 8 + 30; k++) begin
                @(posedge clk);
                #1;
                if (k < 7)
                    check($sformatf("hold_pre%0d", k), next_segment_re, 1'b0);
                else
                    check($sformatf("hold_rel%0d", k - 7), next_segment_re,
                          logic'((k == 7) || exp_repeat(k - 7)));
                if (next_segment_re) npulse++;
            end
`ifdef SEGMENT_STEP_AUTOREPEAT_EN
            check("hold_pulse_count", npulse, 8);
`else
            check("hold_pulse_count", npulse, 1);
`endif
        end
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (12) @(negedge clk);
        check("final_level", btn_level, 1'b0);
        check("final_pulse", next_segment_re, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_segment_step_gen
